// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/decode decoupling buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  // Default datapath width for pc, pcN and inst
  localparam int XLEN = 32;

  // addi x0,x0,0 -- presented to decode whenever nothing is buffered
  localparam logic [31:0] NOP_INST = 32'h00000013;

  // One fetched triple as stored in the buffer
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcN;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fb_ptr.sv
// Modulo-DEPTH pointer register with increment enable and synchronous clear.
// Latency: updated value is visible the cycle after the enabling edge.
// Backpressure: none; the caller gates the enable.
module fb_ptr
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     en,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int AW = $clog2(DEPTH);

  // Pointer register: reset/clear to 0, otherwise advance; DEPTH is a power
  // of two so the natural binary wrap is the modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + AW'(1);
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// IF->ID decoupling FIFO of {pc, pc+4, inst}; NOP on idInst when empty. Optional macro FB_BYPASS_EN.
// Latency: one cycle IF->ID; with FB_BYPASS_EN an empty buffer forwards if* to id* combinationally.
// Backpressure: ifReady (fetch pcEn) = count < DEPTH from registered count only; flush drops everything.
module fetch_buffer #(
  parameter int                         XLEN  = fetch_pkg::XLEN,
  parameter int                         DEPTH = 2,
  parameter logic [fetch_pkg::XLEN-1:0] NOP   = fetch_pkg::NOP_INST
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   ifValid,
  input  logic [XLEN-1:0]        ifPc,
  input  logic [XLEN-1:0]        ifPcN,
  input  logic [XLEN-1:0]        ifInst,
  output logic                   ifReady,
  output logic                   idValid,
  output logic [XLEN-1:0]        idPc,
  output logic [XLEN-1:0]        idPcN,
  output logic [XLEN-1:0]        idInst,
  input  logic                   idReady,
  output logic [$clog2(DEPTH):0] count
);

  import fetch_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry storage is sized by the package XLEN; XLEN is expected to match it.
  fetch_entry_t    mem [DEPTH];
  fetch_entry_t    head;
  logic [AW-1:0]   wrPtr;
  logic [AW-1:0]   rdPtr;
  logic            empty;
  logic            bypass;
  logic            wrEn;
  logic            rdEn;

  assign empty   = (count == '0);
  assign ifReady = (count < CW'(DEPTH));
  assign head    = mem[rdPtr];

`ifdef FB_BYPASS_EN
  // Empty buffer with a live fetch: forward straight to decode unless flushing.
  assign bypass = empty & ifValid & ~flush & ~rst;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed triple taken by decode in the same cycle is never stored.
  assign wrEn = ifValid & ifReady & ~flush & ~rst & ~(bypass & idReady);
  assign rdEn = ~empty & idReady & ~flush & ~rst;

  fb_ptr #(.DEPTH(DEPTH)) uWrPtr (
    .clk  (clk),
    .rst  (rst),
    .clear(flush),
    .en   (wrEn),
    .ptr  (wrPtr)
  );

  fb_ptr #(.DEPTH(DEPTH)) uRdPtr (
    .clk  (clk),
    .rst  (rst),
    .clear(flush),
    .en   (rdEn),
    .ptr  (rdPtr)
  );

  // Entry write; storage itself is never reset, count alone marks validity.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrPtr] <= '{pc: ifPc, pcN: ifPcN, inst: ifInst};
    end
  end

  // Occupancy: reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else begin
      case ({wrEn, rdEn})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Decode-side view: head entry, bypassed fetch, or NOP bubble.
  always_comb begin
    idValid = 1'b0;
    idPc    = '0;
    idPcN   = '0;
    idInst  = NOP;
    if (!empty) begin
      idValid = 1'b1;
      idPc    = head.pc;
      idPcN   = head.pcN;
      idInst  = head.inst;
    end else if (bypass) begin
      idValid = 1'b1;
      idPc    = ifPc;
      idPcN   = ifPcN;
      idInst  = ifInst;
    end
  end

  // Occupancy can never exceed the storage depth.
  assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));

endmodule
